// File: rtl/stack_seq.sv
// Stack-operation sequencer: expands PUSH/POP/CALL/RET/INTR/RTI into
// single-cycle stack memory steps with matching SP update strobes.
//
// state | meaning
// IDLE  | waiting for op_valid
// PSH1  | first push write (data or PC), SP--
// PSH2  | INTR second push write (flags), SP--
// RD1   | first pop read, SP++
// CAP1  | capture first read (POP data, RET PC, RTI flags)
// RD2   | RTI second pop read, SP++
// CAP2  | capture RTI PC
// ERR   | illegal op_code, report and return
module stack_seq #(
  parameter int DW = 8,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [2:0]    op_code,
  input  logic [DW-1:0] sp_in,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] pc_in,
  input  logic [FW-1:0] flags_in,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [DW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          dec_sp,
  output logic          inc_sp,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic [DW-1:0] pc_out,
  output logic          pc_load,
  output logic [FW-1:0] flags_out,
  output logic          flags_load,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PSH1 = 3'd1;
  localparam logic [2:0] PSH2 = 3'd2;
  localparam logic [2:0] RD1  = 3'd3;
  localparam logic [2:0] CAP1 = 3'd4;
  localparam logic [2:0] RD2  = 3'd5;
  localparam logic [2:0] CAP2 = 3'd6;
  localparam logic [2:0] ERR  = 3'd7;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_INTR = 3'b100;
  localparam logic [2:0] OP_RTI  = 3'b101;

  logic [2:0]    state, state_nxt;
  logic [2:0]    op_q;
  logic [DW-1:0] sp_q, data_q, pc_q;
  logic [FW-1:0] flags_q;
  logic [DW-1:0] pop_hold, pc_hold;
  logic [FW-1:0] flags_hold;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_PUSH, OP_CALL, OP_INTR: state_nxt = PSH1;
            OP_POP, OP_RET, OP_RTI:    state_nxt = RD1;
            default:                   state_nxt = ERR;
          endcase
        end
      end
      PSH1:    state_nxt = (op_q == OP_INTR) ? PSH2 : IDLE;
      PSH2:    state_nxt = IDLE;
      RD1:     state_nxt = CAP1;
      CAP1:    state_nxt = (op_q == OP_RTI) ? RD2 : IDLE;
      RD2:     state_nxt = CAP2;
      CAP2:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and operand latch; sp_q tracks the SP strobes we issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= 3'b000;
      sp_q    <= '0;
      data_q  <= '0;
      pc_q    <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && op_valid) begin
        op_q    <= op_code;
        sp_q    <= sp_in;
        data_q  <= data_in;
        pc_q    <= pc_in;
        flags_q <= flags_in;
      end else if (state == PSH1 || state == PSH2) begin
        sp_q <= sp_q - DW'(1);
      end else if (state == RD1 || state == RD2) begin
        sp_q <= sp_q + DW'(1);
      end
    end
  end

  // Strobes and memory interface decoded from the registered state
  always_comb begin
    busy       = (state != IDLE);
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_re     = 1'b0;
    dec_sp     = 1'b0;
    inc_sp     = 1'b0;
    pop_valid  = 1'b0;
    pc_load    = 1'b0;
    flags_load = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      PSH1: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = (op_q == OP_PUSH) ? data_q : pc_q;
        dec_sp    = 1'b1;
        done      = (op_q != OP_INTR);
      end
      PSH2: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = {{(DW-FW){1'b0}}, flags_q};
        dec_sp    = 1'b1;
        done      = 1'b1;
      end
      RD1, RD2: begin
        mem_re   = 1'b1;
        mem_addr = sp_q + DW'(1);
        inc_sp   = 1'b1;
      end
      CAP1: begin
        pop_valid  = (op_q == OP_POP);
        pc_load    = (op_q == OP_RET);
        flags_load = (op_q == OP_RTI);
        done       = (op_q != OP_RTI);
      end
      CAP2: begin
        pc_load = 1'b1;
        done    = 1'b1;
      end
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Read data arrives during the capture step, so it is forwarded while
  // the load pulse is high and held in a register afterwards
  assign pop_data  = pop_valid  ? mem_rdata          : pop_hold;
  assign pc_out    = pc_load    ? mem_rdata          : pc_hold;
  assign flags_out = flags_load ? mem_rdata[FW-1:0]  : flags_hold;

  // Held result registers, updated only on their load pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_hold   <= '0;
      pc_hold    <= '0;
      flags_hold <= '0;
    end else begin
      if (pop_valid)  pop_hold   <= mem_rdata;
      if (pc_load)    pc_hold    <= mem_rdata;
      if (flags_load) flags_hold <= mem_rdata[FW-1:0];
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a simple synchronous stack memory.
module tb_stack_seq;
  localparam int DW = 8;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [2:0]    op_code;
  logic [DW-1:0] sp_in, data_in, pc_in;
  logic [FW-1:0] flags_in;
  logic [DW-1:0] mem_rdata;
  logic          busy, mem_we, mem_re, dec_sp, inc_sp;
  logic [DW-1:0] mem_addr, mem_wdata, pop_data, pc_out;
  logic          pop_valid, pc_load, flags_load, done, err;
  logic [FW-1:0] flags_out;

  // {busy, we, re, dec, inc, done, err, pop_valid, pc_load, flags_load}
  logic [9:0] strb;
  assign strb = {busy, mem_we, mem_re, dec_sp, inc_sp, done, err, pop_valid, pc_load, flags_load};

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [256];

  stack_seq #(.DW(DW), .FW(FW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .sp_in(sp_in), .data_in(data_in), .pc_in(pc_in), .flags_in(flags_in),
    .mem_rdata(mem_rdata), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .dec_sp(dec_sp), .inc_sp(inc_sp),
    .pop_data(pop_data), .pop_valid(pop_valid), .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Stack memory: read data valid the cycle after mem_re
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Present one op at a negedge, let it be accepted, return at N+1 negedge
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] sp,
                       input logic [DW-1:0] d, input logic [DW-1:0] pc,
                       input logic [FW-1:0] fl);
    op_valid = 1'b1; op_code = op; sp_in = sp; data_in = d; pc_in = pc; flags_in = fl;
    @(posedge clk); #1;
    op_valid = 1'b0; sp_in = 8'hEE;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; op_code = 3'b000;
    sp_in = '0; data_in = '0; pc_in = '0; flags_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0) begin miscompares++; $display("FAIL reset_strobes got %b want %b", strb, 10'b0); end
    vectors++;
    if ({pop_data, pc_out, flags_out, mem_addr, mem_wdata} !== '0) begin
      miscompares++; $display("FAIL reset_held got %h %h %h %h %h want 0", pop_data, pc_out, flags_out, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_push;
    issue(3'b000, 8'h7F, 8'hA5, 8'h00, 4'h0);
    vectors++;
    if (strb !== 10'b1101010000) begin miscompares++; $display("FAIL push_strobes got %b want %b", strb, 10'b1101010000); end
    vectors++;
    if ({mem_addr, mem_wdata} !== 16'h7FA5) begin miscompares++; $display("FAIL push_addr_data got %h want 7fa5", {mem_addr, mem_wdata}); end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0) begin miscompares++; $display("FAIL push_idle got %b want 0", strb); end
  endtask

  task automatic test_pop;
    issue(3'b001, 8'h7E, 8'h00, 8'h00, 4'h0);
    vectors++;
    if (strb !== 10'b1010100000 || mem_addr !== 8'h7F) begin
      miscompares++; $display("FAIL pop_read got %b addr %h want %b addr 7f", strb, mem_addr, 10'b1010100000);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b1000010100 || pop_data !== 8'hA5) begin
      miscompares++; $display("FAIL pop_cap got %b data %h want %b data a5", strb, pop_data, 10'b1000010100);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0 || pop_data !== 8'hA5) begin
      miscompares++; $display("FAIL pop_hold got %b data %h want 0 data a5", strb, pop_data);
    end
  endtask

  task automatic test_intr_rti;
    issue(3'b100, 8'h80, 8'h00, 8'h3C, 4'h9);
    vectors++;
    if (strb !== 10'b1101000000 || mem_addr !== 8'h80 || mem_wdata !== 8'h3C) begin
      miscompares++; $display("FAIL intr_psh1 got %b %h %h want %b 80 3c", strb, mem_addr, mem_wdata, 10'b1101000000);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b1101010000 || mem_addr !== 8'h7F || mem_wdata !== 8'h09) begin
      miscompares++; $display("FAIL intr_psh2 got %b %h %h want %b 7f 09", strb, mem_addr, mem_wdata, 10'b1101010000);
    end
    @(negedge clk);
    issue(3'b101, 8'h7E, 8'h00, 8'h00, 4'h0);
    vectors++;
    if (strb !== 10'b1010100000 || mem_addr !== 8'h7F) begin
      miscompares++; $display("FAIL rti_rd1 got %b %h want %b 7f", strb, mem_addr, 10'b1010100000);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b1000000001 || flags_out !== 4'h9) begin
      miscompares++; $display("FAIL rti_flags got %b %h want %b 9", strb, flags_out, 10'b1000000001);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b1010100000 || mem_addr !== 8'h80) begin
      miscompares++; $display("FAIL rti_rd2 got %b %h want %b 80", strb, mem_addr, 10'b1010100000);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b1000010010 || pc_out !== 8'h3C) begin
      miscompares++; $display("FAIL rti_pc got %b %h want %b 3c", strb, pc_out, 10'b1000010010);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0 || pc_out !== 8'h3C || flags_out !== 4'h9) begin
      miscompares++; $display("FAIL rti_hold got %b %h %h want 0 3c 9", strb, pc_out, flags_out);
    end
  endtask

  task automatic test_wrap;
    issue(3'b000, 8'h00, 8'h11, 8'h00, 4'h0);
    vectors++;
    if (strb !== 10'b1101010000 || mem_addr !== 8'h00 || mem_wdata !== 8'h11) begin
      miscompares++; $display("FAIL wrap_push got %b %h %h want %b 00 11", strb, mem_addr, mem_wdata, 10'b1101010000);
    end
    @(negedge clk);
    issue(3'b001, 8'hFF, 8'h00, 8'h00, 4'h0);
    vectors++;
    if (mem_addr !== 8'h00 || mem_re !== 1'b1) begin
      miscompares++; $display("FAIL wrap_pop_addr got %h re %b want 00 re 1", mem_addr, mem_re);
    end
    @(negedge clk);
    vectors++;
    if (pop_data !== 8'h11 || pop_valid !== 1'b1) begin
      miscompares++; $display("FAIL wrap_pop_data got %h pv %b want 11 pv 1", pop_data, pop_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue(3'b110, 8'h50, 8'h00, 8'h00, 4'h0);
    vectors++;
    if (strb !== 10'b1000011000) begin miscompares++; $display("FAIL illegal_110 got %b want %b", strb, 10'b1000011000); end
    @(negedge clk);
    issue(3'b111, 8'h50, 8'h00, 8'h00, 4'h0);
    vectors++;
    if (strb !== 10'b1000011000) begin miscompares++; $display("FAIL illegal_111 got %b want %b", strb, 10'b1000011000); end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0) begin miscompares++; $display("FAIL illegal_idle got %b want 0", strb); end
  endtask

  // A PUSH request held high through an RTI must not be taken
  task automatic test_busy_ignore;
    logic saw_we;
    saw_we = 1'b0;
    issue(3'b101, 8'h7E, 8'h00, 8'h00, 4'h0);
    op_valid = 1'b1; op_code = 3'b000; sp_in = 8'h20; data_in = 8'hCC;
    for (int i = 0; i < 4; i++) begin
      if (mem_we) saw_we = 1'b1;
      if (i < 3) @(negedge clk);
    end
    op_valid = 1'b0;
    vectors++;
    if (saw_we !== 1'b0 || pc_out !== 8'h3C) begin
      miscompares++; $display("FAIL busy_ignore got we_seen %b pc %h want 0 3c", saw_we, pc_out);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0) begin miscompares++; $display("FAIL busy_ignore_idle got %b want 0", strb); end
  endtask

  task automatic test_back_to_back;
    issue(3'b010, 8'h40, 8'h00, 8'h55, 4'h0);
    vectors++;
    if (strb !== 10'b1101010000 || mem_addr !== 8'h40 || mem_wdata !== 8'h55) begin
      miscompares++; $display("FAIL b2b_call got %b %h %h want %b 40 55", strb, mem_addr, mem_wdata, 10'b1101010000);
    end
    @(negedge clk);
    issue(3'b000, 8'h3F, 8'h66, 8'h00, 4'h0);
    vectors++;
    if (strb !== 10'b1101010000 || mem_addr !== 8'h3F || mem_wdata !== 8'h66) begin
      miscompares++; $display("FAIL b2b_push got %b %h %h want %b 3f 66", strb, mem_addr, mem_wdata, 10'b1101010000);
    end
    @(negedge clk);
    issue(3'b011, 8'h3F, 8'h00, 8'h00, 4'h0);
    @(negedge clk);
    vectors++;
    if (strb !== 10'b1000010010 || pc_out !== 8'h55) begin
      miscompares++; $display("FAIL b2b_ret got %b %h want %b 55", strb, pc_out, 10'b1000010010);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(3'b101, 8'h7E, 8'h00, 8'h00, 4'h0);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (strb !== 10'b1010100000) begin miscompares++; $display("FAIL rstmid_rd2 got %b want %b", strb, 10'b1010100000); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0 || pc_out !== 8'h00) begin
      miscompares++; $display("FAIL rstmid_abort got %b pc %h want 0 pc 00", strb, pc_out);
    end
    @(negedge clk);
    vectors++;
    if (strb !== 10'b0) begin miscompares++; $display("FAIL rstmid_quiet got %b want 0", strb); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_intr_rti();
    test_wrap();
    test_illegal();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
